// File: rtl/alarm_input_pio.sv
// alarm_input_pio: Avalon-MM input port with 2-flop sync, edge capture, irq.
// Define ALARM_PIO_DEBOUNCE_EN to add a per-bit debounce filter.
//
// Ports:
//   clk, reset    : clock, async active-high reset
//   address       : 0 DATA, 1 reserved, 2 IRQ_MASK, 3 EDGE_CAPTURE (W1C)
//   chipselect    : slave select
//   write_n       : active-low write strobe
//   writedata     : write data
//   in_port       : asynchronous external input lines
//   readdata      : zero-latency read data, zero-extended
//   irq           : level interrupt, |(edge_capture & irq_mask)
module alarm_input_pio #(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] filtered;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;
    logic             wr_en;
    logic             unused_wd;

    assign wr_en     = chipselect && !write_n;
    assign unused_wd = &{1'b0, writedata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef ALARM_PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt [WIDTH];

    // A bit only follows sync2 after it has disagreed for
    // DEBOUNCE_CYCLES consecutive clocks; any agreement restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filtered <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == filtered[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    filtered[i] <= ~filtered[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end
`else
    localparam int unused_dbc = DEBOUNCE_CYCLES;

    assign filtered = sync2;
`endif

    assign rise = filtered & ~prev;
    assign fall = ~filtered & prev;

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_det = rise;
        end else if (EDGE_TYPE == 1) begin
            edge_det = fall;
        end else begin
            edge_det = rise | fall;
        end
    end

    assign clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // A fresh edge beats a same-cycle clear so no event is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev         <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            prev         <= filtered;
            edge_capture <= edge_det | (edge_capture & ~clr);
            if (wr_en && address == 2'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edge_capture & irq_mask);

    always_comb begin
        readdata = '0;
        unique case (address)
            2'd0:    readdata[WIDTH-1:0] = filtered;
            2'd2:    readdata[WIDTH-1:0] = irq_mask;
            2'd3:    readdata[WIDTH-1:0] = edge_capture;
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_alarm_input_pio.sv
// tb_alarm_input_pio: directed vectors with a queued expected-value
// scoreboard drained by a negedge monitor.
module tb_alarm_input_pio;

    localparam int W = 8;

    logic         clk        = 1'b0;
    logic         reset      = 1'b1;
    logic [1:0]   address    = 2'd0;
    logic         chipselect = 1'b0;
    logic         write_n    = 1'b1;
    logic [31:0]  writedata  = 32'h0;
    logic [W-1:0] in_port    = '0;
    logic [31:0]  readdata;
    logic         irq;
    logic         rd_req     = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   misses  = 0;

    alarm_input_pio #(
        .WIDTH(W),
        .EDGE_TYPE(0),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue the expected view of the state left by the last edge;
    // the monitor compares it at the following negedge.
    task automatic chk(input logic [1:0] a, input logic [31:0] rd,
                       input logic ir, input string nm);
        exp_t e;
        e.name     = nm;
        e.rd       = rd;
        e.irq      = ir;
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        sb.push_back(e);
        rd_req     = 1'b1;
        step(1);
        rd_req     = 1'b0;
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    always @(negedge clk) begin
        if (rd_req) begin
            if (sb.size() == 0) begin
                misses++;
                $display("FAIL sb_underflow: readdata=%h irq=%b, none expected",
                         readdata, irq);
            end else begin
                mon_e = sb.pop_front();
                vectors++;
                if (readdata !== mon_e.rd || irq !== mon_e.irq) begin
                    misses++;
                    $display("FAIL %s: readdata=%h irq=%b, expected readdata=%h irq=%b",
                             mon_e.name, readdata, irq, mon_e.rd, mon_e.irq);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        step(2);
        chk(2'd0, 32'h0, 1'b0, "rst_data");
        chk(2'd1, 32'h0, 1'b0, "rst_resv");
        chk(2'd2, 32'h0, 1'b0, "rst_mask");
        chk(2'd3, 32'h0, 1'b0, "rst_cap");
        reset = 1'b0;
        step(3);

        // rising edge on bit 0 with bit 0 unmasked
        wr(2'd2, 32'h01);
        in_port = 8'h01;
        chk(2'd0, 32'h00, 1'b0, "lat_e0");
        chk(2'd0, 32'h00, 1'b0, "lat_n");
        chk(2'd0, 32'h01, 1'b0, "lat_n1_data");
        chk(2'd3, 32'h01, 1'b1, "lat_n2_cap");
        chk(2'd0, 32'h01, 1'b1, "data_hold");
        wr(2'd3, 32'h01);
        chk(2'd3, 32'h00, 1'b0, "w1c_bit0");
        chk(2'd2, 32'h01, 1'b0, "mask_rd");

        // masked capture, then unmask
        wr(2'd2, 32'h00);
        in_port = 8'h09;
        step(3);
        chk(2'd3, 32'h08, 1'b0, "masked_cap");
        in_port = 8'h01;
        wr(2'd2, 32'h08);
        chk(2'd2, 32'h08, 1'b1, "unmask_irq");
        chk(2'd3, 32'h08, 1'b1, "fall_ignored");
        wr(2'd3, 32'h08);
        chk(2'd3, 32'h00, 1'b0, "w1c_bit3");

        // same-cycle set and clear on bit 2
        in_port = 8'h05;
        step(4);
        chk(2'd3, 32'h04, 1'b0, "cap_bit2");
        in_port = 8'h01;
        step(3);
        in_port = 8'h05;
        step(2);
        wr(2'd3, 32'h04);
        chk(2'd3, 32'h04, 1'b0, "set_wins");
        wr(2'd3, 32'h04);
        chk(2'd3, 32'h00, 1'b0, "w1c_bit2");

        // writes to read-only / reserved addresses
        wr(2'd1, 32'hFF);
        chk(2'd1, 32'h00, 1'b0, "resv_wr");
        wr(2'd0, 32'hFF);
        chk(2'd0, 32'h05, 1'b0, "data_ro");
        chk(2'd2, 32'h08, 1'b0, "mask_kept");

        // reset mid-operation
        in_port = 8'h00;
        step(3);
        in_port = 8'hA5;
        step(4);
        chk(2'd3, 32'hA5, 1'b0, "cap_a5");
        wr(2'd2, 32'hFF);
        chk(2'd2, 32'hFF, 1'b1, "mask_ff");
        in_port = 8'h80;
        reset   = 1'b1;
        chk(2'd3, 32'h00, 1'b0, "rst_mid");
        reset   = 1'b0;
        chk(2'd2, 32'h00, 1'b0, "rel_r0_mask");
        chk(2'd0, 32'h00, 1'b0, "rel_r1_data");
        chk(2'd0, 32'h80, 1'b0, "rel_r2_data");
        chk(2'd3, 32'h80, 1'b0, "rel_r3_cap");
        wr(2'd2, 32'h80);
        chk(2'd3, 32'h80, 1'b1, "rel_irq");

`ifdef ALARM_PIO_DEBOUNCE_EN
        wr(2'd3, 32'hFF);
        chk(2'd3, 32'h00, 1'b0, "db_clr");
        in_port = 8'h81;
        step(3);
        in_port = 8'h80;
        step(6);
        chk(2'd0, 32'h80, 1'b0, "db_glitch_data");
        chk(2'd3, 32'h00, 1'b0, "db_glitch_cap");
        in_port = 8'h81;
        step(5);
        chk(2'd0, 32'h80, 1'b0, "db_pending");
        chk(2'd0, 32'h81, 1'b0, "db_data");
        chk(2'd3, 32'h01, 1'b0, "db_cap");
`endif

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            step(1);
        end
        if (sb.size() != 0) begin
            misses++;
            $display("FAIL sb_drain: %0d left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
